// File: rtl/aes_key_expander.sv
// Sequential AES key schedule: expands a 128/192/256-bit key one word per cycle
// into a round-key buffer that the cipher datapath reads by round index.
module aes_key_expander #(
  parameter int MAX_KEY_BITS = 256,
  parameter int RK_ADDR_W    = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [MAX_KEY_BITS-1:0] key_i,
  input  logic [1:0]              key_len_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    err_o,
  input  logic                    rd_v_i,
  input  logic [RK_ADDR_W-1:0]    rd_addr_i,
  output logic                    rd_v_o,
  output logic [127:0]            rd_data_o,
  output logic [1:0]              state_o
);

  localparam int NR_MAX = (MAX_KEY_BITS >= 256) ? 14 : (MAX_KEY_BITS >= 192) ? 12 : 10;
  localparam int NWORDS = 4 * (NR_MAX + 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [255:0]   win_q;          // word j of the window at [32j+31:32j]; j=0 is newest
  logic [3:0]     nk_q, nr_q;
  logic [5:0]     last_q, cnt_q;
  logic [2:0]     kmod_q;
  logic [7:0]     rcon_q;
  logic           done_q, err_q, rd_v_q;
  logic [127:0]   rd_data_q;
  logic [31:0]    rk_mem [NWORDS];

  logic [3:0]     len_nk, len_nr;
  logic [5:0]     len_last;
  int             len_bits;
  logic           len_ok, legal, accept, load;
  logic [255:0]   key_al, load_win;
  logic [31:0]    prev_w, old_w, new_w;
  logic [127:0]   rk_row;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // v_i/ready_o: a key is taken on every edge where both are high; a read is
  // taken whenever rd_v_i is high and answered with rd_v_o one cycle later.
  assign ready_o   = (state_q != EXPAND);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rd_v_o    = rd_v_q;
  assign rd_data_o = rd_data_q;
  assign state_o   = state_q;

  always_comb begin
    len_nk   = 4'd4;
    len_nr   = 4'd10;
    len_last = 6'd43;
    len_bits = 128;
    len_ok   = 1'b1;
    case (key_len_i)
      2'b00: len_ok = 1'b1;
      2'b01: begin len_nk = 4'd6; len_nr = 4'd12; len_last = 6'd51; len_bits = 192; end
      2'b10: begin len_nk = 4'd8; len_nr = 4'd14; len_last = 6'd59; len_bits = 256; end
      default: len_ok = 1'b0;
    endcase
    legal  = len_ok && (len_bits <= MAX_KEY_BITS);
    accept = v_i && ready_o;
    load   = accept && legal;
  end

  // Right-justifying the left-aligned key leaves key word 0 in window entry Nk-1,
  // so the first Nk cycles simply recirculate the oldest entry.
  always_comb begin
    key_al = '0;
    key_al[255 -: MAX_KEY_BITS] = key_i;
    case (len_nk)
      4'd6:    load_win = {64'h0, key_al[255:64]};
      4'd8:    load_win = key_al;
      default: load_win = {128'h0, key_al[255:128]};
    endcase
  end

  always_comb begin
    prev_w = win_q[31:0];
    case (nk_q)
      4'd6:    old_w = win_q[191:160];
      4'd8:    old_w = win_q[255:224];
      default: old_w = win_q[127:96];
    endcase
    if (cnt_q < {2'b00, nk_q})
      new_w = old_w;
    else if (kmod_q == 3'd0)
      new_w = old_w ^ sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && kmod_q == 3'd4)
      new_w = old_w ^ sub_word(prev_w);
    else
      new_w = old_w ^ prev_w;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (load) state_d = EXPAND;
      EXPAND:     if (cnt_q == last_q) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      win_q     <= '0;
      nk_q      <= 4'd4;
      nr_q      <= 4'd0;
      last_q    <= 6'd0;
      cnt_q     <= 6'd0;
      kmod_q    <= 3'd0;
      rcon_q    <= 8'h01;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_v_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !legal;
      if (load) begin
        win_q  <= load_win;
        nk_q   <= len_nk;
        nr_q   <= len_nr;
        last_q <= len_last;
        cnt_q  <= 6'd0;
        kmod_q <= 3'd0;
        rcon_q <= 8'h01;
        done_q <= 1'b0;
      end else begin
        if (state_q == EXPAND) begin
          win_q  <= {win_q[223:0], new_w};
          cnt_q  <= cnt_q + 6'd1;
          kmod_q <= ({1'b0, kmod_q} == nk_q - 4'd1) ? 3'd0 : kmod_q + 3'd1;
          if (cnt_q >= {2'b00, nk_q} && kmod_q == 3'd0) rcon_q <= xtime(rcon_q);
        end
        if (state_q == DONE) done_q <= 1'b1;
      end
      // Reads see done_q before this edge, so a read racing a rekey gets the old schedule.
      if (rd_v_i && done_q) begin
        rd_v_q    <= 1'b1;
        rd_data_q <= (rd_addr_i > nr_q) ? '0 : rk_row;
      end else begin
        rd_v_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == EXPAND) rk_mem[cnt_q] <= new_w;
  end

  always_comb begin
    rk_row = {rk_mem[{rd_addr_i, 2'b00}], rk_mem[{rd_addr_i, 2'b01}],
              rk_mem[{rd_addr_i, 2'b10}], rk_mem[{rd_addr_i, 2'b11}]};
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: known-answer table, corner sequences and random keys
// checked against a FIPS-style key schedule built from GF(2^8) arithmetic.
module tb_aes_key_expander;

  logic         clk, rst_n;
  logic [255:0] key;
  logic [1:0]   key_len;
  logic         kv, rd_v;
  logic [3:0]   rd_addr;
  logic         ready, done, err, rdv;
  logic [127:0] rdata;
  logic [1:0]   state_dbg;

  logic [127:0] k128;
  logic [1:0]   len128;
  logic         v128, rd_v128;
  logic [3:0]   rd_addr128;
  logic         ready128, done128, err128, rdv128;
  logic [127:0] rdata128;
  logic [1:0]   state128;

  aes_key_expander #(.MAX_KEY_BITS(256), .RK_ADDR_W(4)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .key_i(key), .key_len_i(key_len), .v_i(kv),
    .ready_o(ready), .done_o(done), .err_o(err), .rd_v_i(rd_v), .rd_addr_i(rd_addr),
    .rd_v_o(rdv), .rd_data_o(rdata), .state_o(state_dbg)
  );

  aes_key_expander #(.MAX_KEY_BITS(128), .RK_ADDR_W(4)) dut128 (
    .clk_i(clk), .reset_n_i(rst_n), .key_i(k128), .key_len_i(len128), .v_i(v128),
    .ready_o(ready128), .done_o(done128), .err_o(err128), .rd_v_i(rd_v128), .rd_addr_i(rd_addr128),
    .rd_v_o(rdv128), .rd_data_o(rdata128), .state_o(state128)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int           n_vec = 0;
  int           n_bad = 0;
  logic [127:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sbox_t [256];
  logic [31:0] ref_w  [60];
  int          ref_nr;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] b, inv;
    for (int x = 0; x < 256; x++) begin
      b   = 8'(x);
      inv = 8'h00;
      if (b != 8'h00) begin
        inv = 8'h01;
        repeat (254) inv = gf_mul(inv, b);
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand_model(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon   = 8'h01;
    ref_nr = nk + 6;
    for (int i = 0; i < nk; i++) ref_w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (ref_nr + 1); i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_round(input int r);
    if (r > ref_nr) return 128'h0;
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic accept_key(input logic [255:0] k, input logic [1:0] l);
    @(negedge clk);
    key = k; key_len = l; kv = 1'b1;
    @(negedge clk);
    kv = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    int lat;
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk(name, 128'(lat), 128'(exp_lat));
  endtask

  task automatic load_and_check(input logic [255:0] k, input logic [1:0] l);
    int nk;
    nk = 4 + 2 * int'(l);
    accept_key(k, l);
    expand_model(k, nk);
    wait_done(4 * (nk + 7) + 1, "done_latency");
  endtask

  task automatic read1(input int a, output logic v, output logic [127:0] d);
    @(negedge clk);
    rd_v = 1'b1; rd_addr = 4'(a);
    @(negedge clk);
    rd_v = 1'b0;
    v = rdv; d = rdata;
  endtask

  // Issues one read per cycle and checks each result the cycle after.
  task automatic read_rounds(input int lo, input int hi);
    for (int a = lo; a <= hi + 1; a++) begin
      @(negedge clk);
      if (a > lo) begin
        chk("burst_rd_v", 128'(rdv), 128'd1);
        chk("burst_rd_data", rdata, exp_q.pop_front());
      end
      if (a <= hi) begin
        rd_v = 1'b1; rd_addr = 4'(a);
        exp_q.push_back(model_round(a));
      end else begin
        rd_v = 1'b0;
      end
    end
  endtask

  // ---------------- known-answer table ----------------
  typedef struct {
    logic [255:0] key;
    logic [1:0]   len;
    int           addr;
    logic [127:0] exp;
  } kat_t;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  kat_t kats [7];

  initial begin
    logic         v;
    logic [127:0] d, old_r3;
    logic [255:0] cur_key, rk;
    logic [1:0]   cur_len, rl;
    logic         loaded;
    int           highs, dh, nw;

    rst_n = 1'b0; key = '0; key_len = 2'b00; kv = 1'b0; rd_v = 1'b0; rd_addr = 4'd0;
    k128 = '0; len128 = 2'b00; v128 = 1'b0; rd_v128 = 1'b0; rd_addr128 = 4'd0;

    kats[0] = '{KEY128, 2'b00, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    kats[1] = '{KEY128, 2'b00, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    kats[2] = '{KEY128, 2'b00, 11, 128'h0};
    kats[3] = '{KEY192, 2'b01, 12, 128'he98ba06f448c773c8ecc720401002202};
    kats[4] = '{KEY256, 2'b10, 1,  128'h1f352c073b6108d72d9810a30914dff4};
    kats[5] = '{KEY256, 2'b10, 2,  128'h9ba354118e6925afa51a8b5f2067fcde};
    kats[6] = '{KEY256, 2'b10, 14, 128'hfe4890d1e6188d0b046df344706c631e};

    build_sbox();

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(ready), 128'd1);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_rd_v", 128'(rdv), 128'd0);
    chk("rst_rd_data", rdata, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // illegal length in IDLE
    accept_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'b11);
    chk("illegal_err", 128'(err), 128'd1);
    chk("illegal_ready", 128'(ready), 128'd1);
    chk("illegal_done", 128'(done), 128'd0);
    @(negedge clk);
    chk("illegal_err_pulse", 128'(err), 128'd0);

    // known-answer vectors
    loaded = 1'b0; cur_key = '0; cur_len = 2'b00;
    for (int i = 0; i < 7; i++) begin
      if (!loaded || kats[i].key != cur_key || kats[i].len != cur_len) begin
        load_and_check(kats[i].key, kats[i].len);
        cur_key = kats[i].key; cur_len = kats[i].len; loaded = 1'b1;
      end
      read1(kats[i].addr, v, d);
      chk("kat_rd_v", 128'(v), 128'd1);
      chk("kat_rd_data", d, kats[i].exp);
    end

    // illegal length in DONE keeps the schedule
    accept_key(KEY128, 2'b11);
    chk("illegal_done_err", 128'(err), 128'd1);
    chk("illegal_done_keeps", 128'(done), 128'd1);
    read1(14, v, d);
    chk("illegal_done_rd", d, 128'hfe4890d1e6188d0b046df344706c631e);

    // reset at word 20 of an AES-256 expansion
    accept_key(KEY256, 2'b10);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_done", 128'(done), 128'd0);
    chk("midrst_ready", 128'(ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    read1(4, v, d);
    chk("midrst_rd_v", 128'(v), 128'd0);
    load_and_check(KEY128, 2'b00);
    read1(10, v, d);
    chk("midrst_reload_r10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // rekey in the same cycle as a read of round 3
    old_r3 = model_round(3);
    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rl = 2'($urandom_range(0, 2));
    @(negedge clk);
    key = rk; key_len = rl; kv = 1'b1; rd_v = 1'b1; rd_addr = 4'd3;
    @(negedge clk);
    kv = 1'b0; rd_v = 1'b0;
    chk("rekey_rd_v", 128'(rdv), 128'd1);
    chk("rekey_old_r3", rdata, old_r3);
    chk("rekey_done_drop", 128'(done), 128'd0);
    expand_model(rk, 4 + 2 * int'(rl));
    read1(2, v, d);
    chk("expand_rd_v", 128'(v), 128'd0);
    chk("expand_rd_hold", d, old_r3);
    wait_done(4 * (ref_nr + 1) + 1 - 2, "rekey_latency");
    read_rounds(0, ref_nr + 1);

    // v_i held high: a new expansion starts every time DONE is reached
    expand_model(KEY128, 4);
    nw = 44; highs = 0; dh = 0;
    @(negedge clk);
    key = KEY128; key_len = 2'b00; kv = 1'b1;
    for (int n = 0; n < 2 * nw + 2; n++) begin
      @(negedge clk);
      if (ready) highs++;
      if (done) dh++;
    end
    kv = 1'b0;
    chk("held_v_ready_cycles", 128'(highs), 128'd2);
    chk("held_v_done_low", 128'(dh), 128'd0);
    wait_done(1, "held_v_final_done");
    read1(10, v, d);
    chk("held_v_r10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // random keys against the model
    for (int t = 0; t < 6; t++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rl = 2'($urandom_range(0, 2));
      load_and_check(rk, rl);
      read_rounds(0, ref_nr + 1);
      read1($urandom_range(ref_nr + 1, 15), v, d);
      chk("rand_oob_rd_v", 128'(v), 128'd1);
      chk("rand_oob_rd_data", d, 128'h0);
    end

    // MAX_KEY_BITS=128 instance: longer keys rejected, 128-bit keys expand
    foreach (kats[i]) if (i < 2) begin
      @(negedge clk);
      k128 = 128'($urandom); len128 = (i == 0) ? 2'b10 : 2'b01; v128 = 1'b1;
      @(negedge clk);
      v128 = 1'b0;
      chk("max128_err", 128'(err128), 128'd1);
      chk("max128_ready", 128'(ready128), 128'd1);
      chk("max128_done", 128'(done128), 128'd0);
    end
    @(negedge clk);
    k128 = KEY128[255:128]; len128 = 2'b00; v128 = 1'b1;
    @(negedge clk);
    v128 = 1'b0;
    begin
      int lat;
      lat = 0;
      while (!done128 && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      chk("max128_latency", 128'(lat), 128'd45);
    end
    for (int a = 10; a <= 11; a++) begin
      @(negedge clk);
      rd_v128 = 1'b1; rd_addr128 = 4'(a);
      @(negedge clk);
      rd_v128 = 1'b0;
      chk("max128_rd_v", 128'(rdv128), 128'd1);
      chk("max128_rd_data", rdata128, (a == 10) ? 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 : 128'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
